fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: constants and entry type shared by the fetch queue and
// its users.
//   FQ_ENTRY_WD  : width of one stored entry ({pc, inst})
//   FQ_DEPTH_DEF : default number of queue entries
//   FQ_POP_W_DEF : default number of presentation / pop slots
//   fq_entry_t   : one queue entry, pc in the upper half, inst in the lower
package fetch_queue_pkg;

  localparam int FQ_ENTRY_WD  = 64;
  localparam int FQ_DEPTH_DEF = 8;
  localparam int FQ_POP_W_DEF = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction fetch queue between fetch and decode.
// One instruction may be pushed per cycle; up to POP_W of the oldest entries
// are presented on the output slots and the consumer takes pop_num of them.
//
// Ports
//   clk          in   single clock, all state updates on the rising edge
//   resetn       in   asynchronous active-low reset
//   flush        in   discard all contents (overrides push and pop)
//   push_valid   in   an instruction is pushed this cycle
//   push_pc      in   PC of the pushed instruction
//   push_inst    in   pushed instruction word
//   full         out  registered, count == DEPTH
//   almost_full  out  registered, count >= DEPTH-1
//   out_valid    out  bit i set when slot i holds a valid entry
//   out_pc       out  PCs of slots 0..POP_W-1, slot 0 oldest
//   out_inst     out  instruction words of slots 0..POP_W-1
//   pop_num      in   number of entries taken this cycle (0..POP_W)
//   overflow     out  sticky, set when a push was dropped; cleared by reset
//
// Configuration macro
//   FETCH_QUEUE_BYPASS_EN : a push into an empty queue is presented on slot 0
//                           in the same cycle; if it is also popped that
//                           cycle it is never written into storage.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEF,
  parameter int POP_W = FQ_POP_W_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 push_valid,
  input  logic [31:0]          push_pc,
  input  logic [31:0]          push_inst,
  output logic                 full,
  output logic                 almost_full,
  output logic [POP_W-1:0]     out_valid,
  output logic [32*POP_W-1:0]  out_pc,
  output logic [32*POP_W-1:0]  out_inst,
  input  logic [1:0]           pop_num,
  output logic                 overflow
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POP_MAX = (AW+1)'(POP_W);

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          byp;
  logic          accept;
  logic          byp_taken;
  logic          store;
  logic [AW:0]   pop_req;
  logic [AW:0]   avail;
  logic [AW:0]   pop_eff;
  logic [AW:0]   pop_mem;
  logic [AW:0]   count_next;

  // Pop and push resolution. A pop request larger than what is available is
  // clamped so the queue can never underflow. In bypass builds an incoming
  // push to an empty queue counts as available for popping; when it is
  // popped immediately it never reaches storage.
  always_comb begin
    pop_req    = ((AW+1)'(pop_num) > POP_MAX) ? POP_MAX : (AW+1)'(pop_num);
    byp        = BYPASS && (count == '0) && push_valid && !flush;
    avail      = count + (AW+1)'(byp);
    pop_eff    = (pop_req > avail) ? avail : pop_req;
    accept     = push_valid && !flush && ((count != DEPTH_C) || (pop_eff != '0));
    byp_taken  = byp && (pop_eff != '0);
    store      = accept && !byp_taken;
    pop_mem    = pop_eff - (AW+1)'(byp_taken);
    count_next = count + (AW+1)'(store) - pop_mem;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else if (flush) begin
      // overflow is deliberately kept across a flush: it records a lost
      // instruction, which a redirect does not undo.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr      <= rd_ptr + pop_mem[AW-1:0];
      count       <= count_next;
      full        <= (count_next == DEPTH_C);
      almost_full <= (count_next >= DEPTH_C - (AW+1)'(1));
      if (push_valid && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: it is only ever read through a valid slot.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
    end
  end

  // Slot data is forced to zero while the slot is invalid so stale storage
  // contents are never visible on the outputs.
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    for (int i = 0; i < POP_W; i++) begin
      if (count > (AW+1)'(i)) begin
        out_valid[i]        = 1'b1;
        out_pc[32*i +: 32]   = mem[rd_ptr + AW'(i)].pc;
        out_inst[32*i +: 32] = mem[rd_ptr + AW'(i)].inst;
      end
    end
    if (byp) begin
      out_valid[0]   = 1'b1;
      out_pc[31:0]   = push_pc;
      out_inst[31:0] = push_inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue (DEPTH 8, POP_W 2).
// The reference model is a plain queue of {pc, inst} entries updated from the
// push/pop/flush rules; outputs are sampled mid-cycle on the falling edge.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int POP_W = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk        = 1'b0;
  logic                resetn     = 1'b1;
  logic                flush      = 1'b0;
  logic                push_valid = 1'b0;
  logic [31:0]         push_pc    = '0;
  logic [31:0]         push_inst  = '0;
  logic [1:0]          pop_num    = '0;
  logic                full;
  logic                almost_full;
  logic [POP_W-1:0]    out_valid;
  logic [32*POP_W-1:0] out_pc;
  logic [32*POP_W-1:0] out_inst;
  logic                overflow;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  bit          m_ovf = 1'b0;

  bit          seq_mode   = 1'b0;
  logic [31:0] seq_next   = '0;
  int          seq_popped = 0;

  fetch_queue #(.DEPTH(DEPTH), .POP_W(POP_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .push_valid  (push_valid),
    .push_pc     (push_pc),
    .push_inst   (push_inst),
    .full        (full),
    .almost_full (almost_full),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .pop_num     (pop_num),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of entries actually taken this cycle according to the rules.
  function automatic int model_k(input logic pv, input logic [1:0] pn, input logic fl);
    int n;
    int req;
    int avail;
    if (fl) return 0;
    n     = mq.size();
    req   = (int'(pn) > POP_W) ? POP_W : int'(pn);
    avail = n + ((BYP && n == 0 && pv) ? 1 : 0);
    return (req < avail) ? req : avail;
  endfunction

  task automatic check_outputs(input logic pv, input logic [31:0] pc,
                               input logic [31:0] in, input logic fl);
    logic [POP_W-1:0] ev;
    logic [31:0]      epc [POP_W];
    logic [31:0]      ein [POP_W];
    int               n;
    n  = mq.size();
    ev = '0;
    for (int i = 0; i < POP_W; i++) begin
      epc[i] = '0;
      ein[i] = '0;
      if (i < n) begin
        ev[i]  = 1'b1;
        epc[i] = mq[i][63:32];
        ein[i] = mq[i][31:0];
      end
    end
    if (BYP && n == 0 && pv && !fl) begin
      ev[0]  = 1'b1;
      epc[0] = pc;
      ein[0] = in;
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    for (int i = 0; i < POP_W; i++) begin
      if (ev[i]) begin
        chk("slot_pc", 64'(out_pc[32*i +: 32]), 64'(epc[i]));
        chk("slot_inst", 64'(out_inst[32*i +: 32]), 64'(ein[i]));
      end
    end
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(n >= DEPTH - 1));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic model_update(input logic pv, input logic [31:0] pc, input logic [31:0] in,
                              input logic [1:0] pn, input logic fl);
    int k;
    int n;
    k = model_k(pv, pn, fl);
    n = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (pv) begin
        if (n < DEPTH || k > 0) mq.push_back({pc, in});
        else m_ovf = 1'b1;
      end
      for (int j = 0; j < k; j++) mq.delete(0);
    end
  endtask

  // One clock cycle: starts 1 time unit after a rising edge, ends likewise.
  task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] in,
                      input logic [1:0] pn, input logic fl);
    int k;
    push_valid = pv;
    push_pc    = pc;
    push_inst  = in;
    pop_num    = pn;
    flush      = fl;
    #4;
    check_outputs(pv, pc, in, fl);
    k = model_k(pv, pn, fl);
    if (seq_mode) begin
      for (int j = 0; j < k; j++) begin
        chk("seq_pc", 64'(out_pc[32*j +: 32]), 64'(seq_next + 32'(4 * j)));
      end
      seq_next   = seq_next + 32'(4 * k);
      seq_popped = seq_popped + k;
    end
    @(posedge clk);
    model_update(pv, pc, in, pn, fl);
    #1;
    push_valid = 1'b0;
    pop_num    = '0;
    flush      = 1'b0;
  endtask

  initial begin
    int          pushed;
    logic        pv;
    logic [1:0]  pn;
    logic [31:0] base;

    // Reset state
    #2 resetn = 1'b0;
    #10;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_almost_full", 64'(almost_full), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // First push: visible next cycle (same cycle with bypass, checked in step)
    step(1'b1, 32'hBFC0_0000, 32'h2401_0001, 2'd0, 1'b0);
    chk("first_push_valid", 64'(out_valid), 64'h1);
    chk("first_push_pc", 64'(out_pc[31:0]), 64'hBFC0_0000);

    // Fill to DEPTH, then one more push is dropped
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h2401_0001 + 32'(i), 2'd0, 1'b0);
      if (i == DEPTH - 2) chk("af_at_7", 64'(almost_full), 64'h1);
    end
    chk("fill_full", 64'(full), 64'h1);
    step(1'b1, 32'hBFC0_0020, 32'h2401_0009, 2'd0, 1'b0);
    chk("ovf_set", 64'(overflow), 64'h1);
    chk("ovf_slot0", 64'(out_pc[31:0]), 64'hBFC0_0000);
    chk("ovf_full", 64'(full), 64'h1);

    // Down to 5 entries, then pop 2 with a push
    step(1'b0, '0, '0, 2'd2, 1'b0);
    step(1'b0, '0, '0, 2'd1, 1'b0);
    step(1'b1, 32'hBFC0_0100, 32'h0000_0100, 2'd2, 1'b0);
    chk("pop2_push_valid", 64'(out_valid), 64'h3);
    chk("pop2_push_slot0", 64'(out_pc[31:0]), 64'hBFC0_0014);
    chk("pop2_push_af", 64'(almost_full), 64'h0);

    // Flush with push and pop on a queue of 6
    step(1'b1, 32'hBFC0_0104, 32'h0000_0104, 2'd0, 1'b0);
    step(1'b1, 32'hBFC0_0108, 32'h0000_0108, 2'd0, 1'b0);
    step(1'b1, 32'hDEAD_0000, 32'hDEAD_0001, 2'd2, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_full", 64'(full), 64'h0);
    chk("flush_af", 64'(almost_full), 64'h0);
    step(1'b0, '0, '0, 2'd0, 1'b0);

    // 20 pushes / 20 pops across pointer wrap, popped PCs strictly +4
    base       = 32'h8000_0000;
    seq_mode   = 1'b1;
    seq_next   = base;
    seq_popped = 0;
    pushed     = 0;
    for (int c = 0; c < 400 && seq_popped < 20; c++) begin
      pv = (pushed < 20) && (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      pn = 2'($urandom_range(0, POP_W));
      step(pv, base + 32'(4 * pushed), ~(base + 32'(4 * pushed)), pn, 1'b0);
      if (pv) pushed++;
    end
    seq_mode = 1'b0;
    chk("seq_popped", 64'(seq_popped), 64'd20);

    // Random traffic including overfill, over-pop and occasional flush
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           2'($urandom_range(0, POP_W)), 1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset mid-stream with three entries held
    step(1'b0, '0, '0, 2'd0, 1'b1);
    step(1'b1, 32'h0000_1000, 32'h1, 2'd0, 1'b0);
    step(1'b1, 32'h0000_1004, 32'h2, 2'd0, 1'b0);
    step(1'b1, 32'h0000_1008, 32'h3, 2'd0, 1'b0);
    step(1'b1, 32'h0000_100C, 32'h4, 2'd0, 1'b1);
    step(1'b1, 32'h0000_2000, 32'h5, 2'd0, 1'b0);
    step(1'b1, 32'h0000_2004, 32'h6, 2'd0, 1'b0);
    step(1'b1, 32'h0000_2008, 32'h7, 2'd0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'h3);
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_overflow", 64'(overflow), 64'h0);
    chk("mid_rst_full", 64'(full), 64'h0);
    mq.delete();
    m_ovf = 1'b0;
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h0000_3000, 32'h8, 2'd0, 1'b0);
    step(1'b0, '0, '0, 2'd1, 1'b0);
    chk("post_rst_empty", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
